item_cfg_arbiter: RTL and testbench

//  Owns the single-port item configuration RAM and shares it between two requesters:
//  the APB register slave (host read/write) and the vend FSM (item lookup, dispense update).

---
 rtl/vend_pkg.sv | 28 ++
 rtl/item_cfg_arbiter_rr_arb2.sv | 42 ++++
 rtl/item_cfg_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_item_cfg_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and RAM word layout for the vend item configuration path.
// Word layout: [31:24] sold, [23:16] available, [15:0] cost.
package vend_pkg;

    localparam int WORD_W    = 32;
    localparam int COST_LSB  = 0;
    localparam int AVAIL_LSB = 16;
    localparam int SOLD_LSB  = 24;

    // WDONE completes writes and refused/out-of-range ops; DONE completes RAM reads.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDONE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        REQ_APB = 1'b0,
        REQ_FSM = 1'b1
    } req_id_t;

    // One dispense: sold+1 (wraps), avail-1, cost unchanged.
    function automatic logic [WORD_W-1:0] dispense_word(input logic [WORD_W-1:0] w);
        return {w[SOLD_LSB +: 8] + 8'd1, w[AVAIL_LSB +: 8] - 8'd1, w[COST_LSB +: 16]};
    endfunction

endpackage

// File: rtl/item_cfg_arbiter_rr_arb2.sv
// Two-way round-robin arbiter (APB vs FSM) with an APB priority override.
// The pointer remembers the last granted requester and advances on every accepted grant.
module rr_arb2
    import vend_pkg::*;
(
    input  logic    pclk,
    input  logic    prstn,
    input  logic    req_apb,
    input  logic    req_fsm,
    input  logic    prio_apb,
    input  logic    take,
    output logic    gnt_valid,
    output req_id_t gnt_id
);

    req_id_t last_r;

    // Last-granted pointer; FSM after reset so APB wins the first tie.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            last_r <= REQ_FSM;
        end else if (take) begin
            last_r <= gnt_id;
        end
    end

    // Grant selection.
    always_comb begin
        gnt_valid = req_apb | req_fsm;
        gnt_id    = REQ_APB;
        if (req_apb && req_fsm && !prio_apb) begin
            gnt_id = (last_r == REQ_APB) ? REQ_FSM : REQ_APB;
        end else if (req_apb) begin
            gnt_id = REQ_APB;
        end else if (req_fsm) begin
            gnt_id = REQ_FSM;
        end else begin
            gnt_id = REQ_APB;
        end
    end

endmodule

// File: rtl/item_cfg_arbiter.sv
// Owns the single-port item configuration RAM, sharing it between APB host access and
// vend FSM lookups/atomic dispense updates. Optional ITEM_CFG_ARB_STATS_EN adds counters.
module item_cfg_arbiter
    import vend_pkg::*;
#(
    parameter  int MAX_ITEMS = 1024,
    parameter  int DATA_W    = 32,
    localparam int IDX_W     = $clog2(MAX_ITEMS)
) (
    input  logic              pclk,
    input  logic              prstn,
    input  logic              cfg_mode,
    input  logic [IDX_W-1:0]  num_items,
    input  logic              apb_req,
    input  logic              apb_we,
    input  logic [IDX_W-1:0]  apb_idx,
    input  logic [DATA_W-1:0] apb_wdata,
    output logic              apb_done,
    output logic [DATA_W-1:0] apb_rdata,
    output logic              apb_err,
    input  logic              fsm_rd_req,
    input  logic              fsm_upd_req,
    input  logic [IDX_W-1:0]  fsm_idx,
    output logic              fsm_done,
    output logic [15:0]       item_cost,
    output logic [7:0]        item_avail,
    output logic              fsm_err,
`ifdef ITEM_CFG_ARB_STATS_EN
    output logic [15:0]       stat_disp,
    output logic [15:0]       stat_conflict,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [IDX_W-1:0]  mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t       state_r, state_s;
    req_id_t          win_r, gnt_id_s;
    logic             upd_r;
    logic [IDX_W-1:0] idx_r;
    logic             gnt_valid_s, take_s, fsm_any_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             oor_s, refuse_s, avail_zero_s, wb_s;

    assign fsm_any_s    = fsm_rd_req | fsm_upd_req;
    assign take_s       = (state_r == ST_IDLE) && gnt_valid_s;
    assign sel_idx_s    = (gnt_id_s == REQ_APB) ? apb_idx : fsm_idx;
    assign oor_s        = (sel_idx_s >= num_items);
    assign refuse_s     = (gnt_id_s == REQ_FSM) && fsm_upd_req && cfg_mode;
    assign avail_zero_s = (mem_rdata[AVAIL_LSB +: 8] == 8'd0);
    assign wb_s         = (state_r == ST_RWAIT) && (win_r == REQ_FSM) && upd_r && !avail_zero_s;

    rr_arb2 u_rr (
        .pclk      (pclk),
        .prstn     (prstn),
        .req_apb   (apb_req),
        .req_fsm   (fsm_any_s),
        .prio_apb  (cfg_mode),
        .take      (take_s),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // State register and captured operation context.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_r <= ST_IDLE;
            win_r   <= REQ_APB;
            upd_r   <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (take_s) begin
                win_r <= gnt_id_s;
                upd_r <= fsm_upd_req;
                idx_r <= sel_idx_s;
            end
        end
    end

    // Next state and RAM strobes.
    always_comb begin
        state_s   = state_r;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {IDX_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (!take_s) begin
                    state_s = ST_IDLE;
                end else if (oor_s || refuse_s) begin
                    state_s = ST_WDONE;
                end else if ((gnt_id_s == REQ_APB) && apb_we) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = apb_idx;
                    mem_wdata = apb_wdata;
                    state_s   = ST_WDONE;
                end else begin
                    mem_en   = 1'b1;
                    mem_addr = sel_idx_s;
                    state_s  = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                if (wb_s) begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = idx_r;
                    mem_wdata = dispense_word(mem_rdata);
                end else begin
                    mem_en = 1'b0;
                end
                state_s = ST_DONE;
            end
            ST_WDONE: state_s = ST_IDLE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Completion pulses and result registers; results hold between operations.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            apb_done   <= 1'b0;
            apb_err    <= 1'b0;
            apb_rdata  <= {DATA_W{1'b0}};
            fsm_done   <= 1'b0;
            fsm_err    <= 1'b0;
            item_cost  <= 16'd0;
            item_avail <= 8'd0;
        end else begin
            apb_done <= 1'b0;
            fsm_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (take_s && (state_s == ST_WDONE)) begin
                        if (gnt_id_s == REQ_APB) begin
                            apb_done <= 1'b1;
                            apb_err  <= oor_s;
                        end else begin
                            fsm_done <= 1'b1;
                            fsm_err  <= 1'b1;
                        end
                    end
                end
                ST_RWAIT: begin
                    if (win_r == REQ_APB) begin
                        apb_done  <= 1'b1;
                        apb_err   <= 1'b0;
                        apb_rdata <= mem_rdata;
                    end else begin
                        fsm_done   <= 1'b1;
                        fsm_err    <= upd_r && avail_zero_s;
                        item_cost  <= mem_rdata[COST_LSB +: 16];
                        item_avail <= mem_rdata[AVAIL_LSB +: 8];
                    end
                end
                default: begin
                    apb_done <= 1'b0;
                end
            endcase
        end
    end

`ifdef ITEM_CFG_ARB_STATS_EN
    // Saturating dispense and contention counters.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            stat_disp     <= 16'd0;
            stat_conflict <= 16'd0;
        end else begin
            if (wb_s && (stat_disp != 16'hFFFF)) begin
                stat_disp <= stat_disp + 16'd1;
            end
            if ((state_r == ST_IDLE) && apb_req && fsm_any_s && (stat_conflict != 16'hFFFF)) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_item_cfg_arbiter.sv
// Self-checking bench for item_cfg_arbiter: directed cases plus randomized traffic
// against a transaction-level reference model and a behavioural RAM.
module tb_item_cfg_arbiter;
    import vend_pkg::*;

    localparam int IW = 10;
    localparam int DW = 32;

    logic          pclk = 1'b0;
    logic          prstn = 1'b0;
    logic          cfg_mode = 1'b0;
    logic [IW-1:0] num_items = 10'd8;
    logic          apb_req = 1'b0, apb_we = 1'b0;
    logic [IW-1:0] apb_idx = 10'd0;
    logic [DW-1:0] apb_wdata = 32'd0;
    logic          apb_done, apb_err;
    logic [DW-1:0] apb_rdata;
    logic          fsm_rd_req = 1'b0, fsm_upd_req = 1'b0;
    logic [IW-1:0] fsm_idx = 10'd0;
    logic          fsm_done, fsm_err;
    logic [15:0]   item_cost;
    logic [7:0]    item_avail;
    logic          mem_en, mem_we;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    item_cfg_arbiter u_dut (
        .pclk(pclk), .prstn(prstn), .cfg_mode(cfg_mode), .num_items(num_items),
        .apb_req(apb_req), .apb_we(apb_we), .apb_idx(apb_idx), .apb_wdata(apb_wdata),
        .apb_done(apb_done), .apb_rdata(apb_rdata), .apb_err(apb_err),
        .fsm_rd_req(fsm_rd_req), .fsm_upd_req(fsm_upd_req), .fsm_idx(fsm_idx),
        .fsm_done(fsm_done), .item_cost(item_cost), .item_avail(item_avail), .fsm_err(fsm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 pclk = ~pclk;

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [1024];
    logic [DW-1:0] ram_q = 32'd0;
    always @(posedge pclk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) ram_q <= ram[mem_addr];
    end
    assign mem_rdata = ram_q;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [DW-1:0] ref_mem [1024];
    bit            m_busy = 1'b0, m_who = 1'b0, m_last = 1'b1, m_undo = 1'b0;
    int            m_cnt = 0;
    logic [IW-1:0] m_undo_idx;
    logic [DW-1:0] m_undo_val;
    bit            e_err, e_rd, e_fields;
    logic [DW-1:0] e_rdata;
    logic [15:0]   e_cost;
    logic [7:0]    e_avail;
    int            exp_en = 0, exp_we = 0, got_en = 0, got_we = 0;

    // Transaction-level model: decides grants in idle cycles, predicts done timing and results.
    always @(negedge pclk) begin
        logic [1:0]    exp_done;
        logic [IW-1:0] idx;
        logic [DW-1:0] w;
        bit            a, f, oor;
        if (!prstn) begin
            if (m_busy && m_undo) begin
                ref_mem[m_undo_idx] = m_undo_val;
                exp_en--;
                exp_we--;
            end
            m_busy = 1'b0; m_last = 1'b1; m_undo = 1'b0;
        end else begin
            if (mem_en) got_en++;
            if (mem_en && mem_we) got_we++;
            exp_done = 2'b00;
            if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) exp_done = m_who ? 2'b01 : 2'b10;
            end
            chk("done", {apb_done, fsm_done}, exp_done);
            if (exp_done != 2'b00) begin
                if (!m_who) begin
                    chk("apb_err", apb_err, e_err);
                    if (e_rd) chk("apb_rdata", apb_rdata, e_rdata);
                end else begin
                    chk("fsm_err", fsm_err, e_err);
                    if (e_fields) begin
                        chk("item_cost", item_cost, e_cost);
                        chk("item_avail", item_avail, e_avail);
                    end
                end
                m_busy = 1'b0;
                m_undo = 1'b0;
            end else if (!m_busy) begin
                a = apb_req;
                f = fsm_rd_req | fsm_upd_req;
                if (a || f) begin
                    if (cfg_mode)   m_who = !a;
                    else if (a && f) m_who = !m_last;
                    else            m_who = !a;
                    m_last = m_who; m_busy = 1'b1;
                    e_rd = 1'b0; e_fields = 1'b0; e_err = 1'b0;
                    idx = m_who ? fsm_idx : apb_idx;
                    oor = (idx >= num_items);
                    if (!m_who) begin
                        if (oor) begin e_err = 1'b1; m_cnt = 1; end
                        else if (apb_we) begin ref_mem[idx] = apb_wdata; m_cnt = 1; exp_en++; exp_we++; end
                        else begin e_rd = 1'b1; e_rdata = ref_mem[idx]; m_cnt = 2; exp_en++; end
                    end else if (oor || (fsm_upd_req && cfg_mode)) begin
                        e_err = 1'b1; m_cnt = 1;
                    end else begin
                        w = ref_mem[idx];
                        e_fields = 1'b1; e_cost = w[15:0]; e_avail = w[23:16];
                        m_cnt = 2; exp_en++;
                        if (fsm_upd_req) begin
                            if (e_avail == 8'd0) e_err = 1'b1;
                            else begin
                                m_undo = 1'b1; m_undo_idx = idx; m_undo_val = w;
                                ref_mem[idx] = {w[31:24] + 8'd1, e_avail - 8'd1, e_cost};
                                exp_en++; exp_we++;
                            end
                        end
                    end
                end
            end
        end
    end

    function automatic logic [DW-1:0] rand_word();
        return {8'($urandom), 8'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    task automatic apb_op(input logic we, input logic [IW-1:0] idx, input logic [DW-1:0] wd, output int lat);
        @(posedge pclk); #1;
        apb_we = we; apb_idx = idx; apb_wdata = wd; apb_req = 1'b1;
        lat = 0;
        do begin @(posedge pclk); #1; lat++; end while (!apb_done && lat < 20);
        if (!apb_done) chk("apb_timeout", apb_done, 1);
        apb_req = 1'b0;
    endtask

    task automatic fsm_op(input logic rd, input logic upd, input logic [IW-1:0] idx, output int lat);
        @(posedge pclk); #1;
        fsm_idx = idx; fsm_rd_req = rd; fsm_upd_req = upd;
        lat = 0;
        do begin @(posedge pclk); #1; lat++; end while (!fsm_done && lat < 20);
        if (!fsm_done) chk("fsm_timeout", fsm_done, 1);
        fsm_rd_req = 1'b0; fsm_upd_req = 1'b0;
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_apb"}, {apb_done, apb_err, apb_rdata}, 0);
        chk({t, "_fsm"}, {fsm_done, fsm_err, item_cost, item_avail}, 0);
        chk({t, "_mem"}, {mem_en, mem_we, mem_addr, mem_wdata}, 0);
    endtask

    task automatic reset_pulse();
        @(posedge pclk); #1;
        prstn = 1'b0; apb_req = 1'b0; fsm_rd_req = 1'b0; fsm_upd_req = 1'b0;
        @(negedge pclk);
        chk_zero("rst");
        @(posedge pclk); #1;
        prstn = 1'b1;
    endtask

    task automatic rand_phase(input int ncyc, input logic cm);
        int c;
        cfg_mode = cm;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge pclk); #1;
            if (apb_done) apb_req = 1'b0;
            if (fsm_done) begin fsm_rd_req = 1'b0; fsm_upd_req = 1'b0; end
            if (!apb_req && $urandom_range(0, 2) == 0) begin
                apb_we = 1'($urandom_range(0, 1)); apb_idx = 10'($urandom_range(0, 9));
                apb_wdata = rand_word(); apb_req = 1'b1;
            end
            if (!(fsm_rd_req || fsm_upd_req) && $urandom_range(0, 2) == 0) begin
                fsm_idx = 10'($urandom_range(0, 9));
                case ($urandom_range(0, 2))
                    0:       begin fsm_rd_req = 1'b1; fsm_upd_req = 1'b0; end
                    1:       begin fsm_rd_req = 1'b0; fsm_upd_req = 1'b1; end
                    default: begin fsm_rd_req = 1'b1; fsm_upd_req = 1'b1; end
                endcase
            end
        end
        c = 0;
        while ((apb_req || fsm_rd_req || fsm_upd_req || m_busy) && c < 60) begin
            @(posedge pclk); #1; c++;
            if (apb_done) apb_req = 1'b0;
            if (fsm_done) begin fsm_rd_req = 1'b0; fsm_upd_req = 1'b0; end
        end
        chk("drain_busy", m_busy, 0);
        @(posedge pclk); #1;
        cfg_mode = 1'b0;
    endtask

    initial begin
        int lat, n, bad, en0, we0;
        logic [3:0] order;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

        @(negedge pclk);
        chk_zero("por");
        @(posedge pclk); #1;
        prstn = 1'b1;

        for (int i = 0; i < 8; i++) apb_op(1'b1, 10'(i), rand_word(), lat);

        apb_op(1'b1, 10'd5, 32'h0003_0A64, lat);
        chk("wr_lat", lat, 1);
        apb_op(1'b0, 10'd5, 32'd0, lat);
        chk("rd_lat", lat, 2);
        chk("rd_data", apb_rdata, 32'h0003_0A64);

        fsm_op(1'b0, 1'b1, 10'd5, lat);
        chk("upd_lat", lat, 2);
        chk("upd_ram", ram[5], 32'h0102_0A64);
        chk("upd_cost", item_cost, 16'h0A64);
        chk("upd_avail", item_avail, 8'h03);
        chk("upd_err", fsm_err, 0);

        apb_op(1'b1, 10'd6, 32'h0700_1234, lat);
        we0 = got_we;
        fsm_op(1'b0, 1'b1, 10'd6, lat);
        chk("sold_err", fsm_err, 1);
        chk("sold_we", got_we, we0);
        chk("sold_ram", ram[6], 32'h0700_1234);

        fsm_op(1'b1, 1'b0, 10'd5, lat);
        chk("look_lat", lat, 2);
        chk("look_avail", item_avail, 8'h02);

        en0 = got_en;
        apb_op(1'b0, 10'd8, 32'd0, lat);
        chk("oor_apb_err", apb_err, 1);
        chk("oor_apb_lat", lat, 1);
        fsm_op(1'b1, 1'b0, 10'd9, lat);
        chk("oor_fsm_err", fsm_err, 1);
        chk("oor_no_ram", got_en, en0);

        cfg_mode = 1'b1;
        fsm_op(1'b0, 1'b1, 10'd5, lat);
        chk("cfg_upd_err", fsm_err, 1);
        chk("cfg_no_ram", got_en, en0);
        chk("cfg_ram5", ram[5], 32'h0102_0A64);
        fsm_op(1'b1, 1'b0, 10'd5, lat);
        chk("cfg_look_err", fsm_err, 0);
        chk("cfg_look_avail", item_avail, 8'h02);
        cfg_mode = 1'b0;

        reset_pulse();
        apb_we = 1'b0; apb_idx = 10'd1; apb_req = 1'b1;
        fsm_idx = 10'd2; fsm_upd_req = 1'b1;
        n = 0; order = 4'd0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(posedge pclk); #1;
            if (apb_done) begin order = {order[2:0], 1'b0}; n++; end
            if (fsm_done) begin order = {order[2:0], 1'b1}; n++; end
        end
        apb_req = 1'b0; fsm_upd_req = 1'b0;
        chk("arb_count", n, 4);
        chk("arb_order", order, 4'b0101);

        apb_op(1'b1, 10'd3, 32'h0005_0111, lat);
        @(posedge pclk); #1;
        fsm_idx = 10'd3; fsm_upd_req = 1'b1;
        @(posedge pclk); #2;
        prstn = 1'b0; fsm_upd_req = 1'b0;
        #1;
        chk_zero("rmw_rst");
        @(posedge pclk); #1;
        chk_zero("rmw_rst_clk");
        chk("rmw_state", 64'(u_dut.state_r), 64'(ST_IDLE));
        chk("rmw_ram", ram[3], 32'h0005_0111);
        prstn = 1'b1;

        rand_phase(600, 1'b0);
        rand_phase(300, 1'b1);

        chk("mem_en_count", got_en, exp_en);
        chk("mem_we_count", got_we, exp_we);
        bad = 0;
        for (int i = 0; i < 8; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("ram_image", bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
